// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and widths for the SDRAM command arbiter.
package sdram_arb_pkg;
  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 16;
  typedef struct packed {
    logic                    we;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] data;
  } sdram_cmd_t;
  typedef enum logic [1:0] {RET_IDLE, RET_POP, RET_CAP} ret_state_t;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: first-word-fall-through FIFO of read-issuer indices.
module tag_fifo #(
  parameter int W          = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]          mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  do_push, do_pop;
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;
  assign head    = mem_q[rp_q];
  assign full    = cnt_q[DEPTH_LOG2];
  assign empty   = cnt_q == '0;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + DEPTH_LOG2'(do_push);
      rp_q  <= rp_q + DEPTH_LOG2'(do_pop);
      cnt_q <= cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: round-robin command arbiter with in-order read-data return routing.
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TAG_DEPTH_LOG2 = 4
) (
  input  logic                                clk,
  input  logic                                rst_i,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ-1:0]                    we_i,
  input  logic [N_REQ-1:0][SDRAM_ADDR_W-1:0]  addr_i,
  input  logic [N_REQ-1:0][SDRAM_DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]                    gnt_o,
  output logic [SDRAM_DATA_W-1:0]             rdata_o,
  output logic [N_REQ-1:0]                    rvalid_o,
  output logic [40:0]                         cmd_d_o,
  output logic                                cmd_enq_o,
  input  logic                                cmd_alm_full_i,
  input  logic [SDRAM_DATA_W-1:0]             rd_q_i,
  output logic                                rd_deq_o,
  input  logic                                rd_empty_i
);
  localparam int IDX_W = $clog2(N_REQ);
  logic [IDX_W-1:0]        rr_q, rr_d, win, tag_head;
  logic [N_REQ-1:0]        elig, gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic                    found, tag_full, tag_empty, tag_pop, start;
  logic                    enq_q, deq_q;
  logic [SDRAM_DATA_W-1:0] rdata_q, rdata_d;
  sdram_cmd_t              cmd_q, cmd_d;
  ret_state_t              state_q, state_d;
  int                      j;
  assign elig = req_i & ~gnt_q & (we_i | {N_REQ{!tag_full}}) & {N_REQ{!cmd_alm_full_i}};
  // First eligible index scanning upward from rr, wrapping at N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
    rr_d  = !found ? rr_q : (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
    gnt_d = found ? N_REQ'(1) << win : '0;
    cmd_d = found ? {we_i[win], addr_i[win], wdata_i[win]} : cmd_q;
  end
  // Return path: dequeue, wait one cycle for FIFO q latency, then capture and route.
  always_comb begin
    start    = state_q == RET_IDLE && !rd_empty_i && !tag_empty;
    tag_pop  = state_q == RET_CAP;
    state_d  = start ? RET_POP : (state_q == RET_POP) ? RET_CAP : RET_IDLE;
    rvalid_d = tag_pop ? N_REQ'(1) << tag_head : '0;
    rdata_d  = tag_pop ? rd_q_i : rdata_q;
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      gnt_q    <= '0;
      enq_q    <= 1'b0;
      cmd_q    <= '0;
      state_q  <= RET_IDLE;
      deq_q    <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      enq_q    <= found;
      cmd_q    <= cmd_d;
      state_q  <= state_d;
      deq_q    <= start;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
  tag_fifo #(.W(IDX_W), .DEPTH_LOG2(TAG_DEPTH_LOG2)) u_tag_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push_i(found && !we_i[win]),
    .pop_i (tag_pop),
    .din_i (win),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );
  assign gnt_o     = gnt_q;
  assign cmd_enq_o = enq_q;
  assign cmd_d_o   = cmd_q;
  assign rd_deq_o  = deq_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter: directed scenarios with hand-computed expectations.
module tb_sdram_cmd_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req, we, gnt, rvalid;
  logic [2:0][23:0] addr;
  logic [2:0][15:0] wdata;
  logic [15:0]      rdata;
  logic [40:0]      cmd;
  logic             enq, alm, deq, rd_empty;
  logic [15:0]      rd_q = '0;
  logic [15:0]      rdmem [32];
  int               rd_wr = 0, rd_rd = 0;
  int               total = 0, bad = 0;

  always #5 clk = ~clk;

  sdram_cmd_arbiter #(.N_REQ(3), .TAG_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rdata_o(rdata), .rvalid_o(rvalid), .cmd_d_o(cmd), .cmd_enq_o(enq),
    .cmd_alm_full_i(alm), .rd_q_i(rd_q), .rd_deq_o(deq), .rd_empty_i(rd_empty)
  );

  // Read-data FIFO model: one-cycle q latency; the controller is reset together with the arbiter.
  assign rd_empty = rd_wr == rd_rd;
  always @(posedge clk or posedge rst) begin
    if (rst) rd_rd <= rd_wr;
    else if (deq) begin
      rd_q  <= rdmem[rd_rd % 32];
      rd_rd <= rd_rd + 1;
    end
  end

  task automatic rd_push(input logic [15:0] d);
    rdmem[rd_wr % 32] = d;
    rd_wr = rd_wr + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; alm = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; alm = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    total += 6;
    if (gnt !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b exp=000", gnt); end
    if (rvalid !== 3'b000) begin bad++; $display("FAIL rst_rvalid got=%b exp=000", rvalid); end
    if (enq !== 1'b0) begin bad++; $display("FAIL rst_enq got=%b exp=0", enq); end
    if (deq !== 1'b0) begin bad++; $display("FAIL rst_deq got=%b exp=0", deq); end
    if (cmd !== 41'h0) begin bad++; $display("FAIL rst_cmd got=%h exp=0", cmd); end
    if (rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 3'b000 || enq !== 1'b0) begin bad++; $display("FAIL idle_after_rst gnt=%b enq=%b exp 000/0", gnt, enq); end
  endtask

  task automatic test_single_write();
    bit seen = 0;
    req = 3'b010; we = 3'b010; addr[1] = 24'h000123; wdata[1] = 16'hBEEF;
    @(negedge clk);
    total += 3;
    if (gnt !== 3'b010) begin bad++; $display("FAIL wr_gnt got=%b exp=010", gnt); end
    if (enq !== 1'b1) begin bad++; $display("FAIL wr_enq got=%b exp=1", enq); end
    if (cmd !== 41'h1_000123_BEEF) begin bad++; $display("FAIL wr_cmd got=%h exp=1000123beef", cmd); end
    req = '0;
    @(negedge clk);
    total++;
    if (gnt !== 3'b000 || enq !== 1'b0) begin bad++; $display("FAIL wr_pulse gnt=%b enq=%b exp 000/0", gnt, enq); end
    rd_push(16'h7777);
    repeat (6) begin
      @(negedge clk);
      if (deq || rvalid != 0) seen = 1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL wr_no_tag got deq/rvalid=%b exp=0", seen); end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    req = 3'b111; we = 3'b111;
    for (int k = 0; k < 3; k++) addr[k] = 24'h100 + 24'(k);
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      exp_g = 3'b001 << (n % 3);
      total += 2;
      if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", n, gnt, exp_g); end
      if (cmd[39:16] !== 24'h100 + 24'(n % 3)) begin bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", n, cmd[39:16], 24'h100 + 24'(n % 3)); end
    end
    req = '0;
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_read_routing();
    int got = 0;
    req = 3'b100; we = 3'b000; addr[2] = 24'h10;
    @(negedge clk);
    total += 2;
    if (gnt !== 3'b100) begin bad++; $display("FAIL rd2_gnt got=%b exp=100", gnt); end
    if (cmd !== 41'h0_000010_0000) begin bad++; $display("FAIL rd2_cmd got=%h exp=0000100000", cmd); end
    req = 3'b001; addr[0] = 24'h20;
    @(negedge clk);
    total += 2;
    if (gnt !== 3'b001) begin bad++; $display("FAIL rd0_gnt got=%b exp=001", gnt); end
    if (cmd !== 41'h0_000020_0000) begin bad++; $display("FAIL rd0_cmd got=%h exp=0000200000", cmd); end
    req = '0;
    rd_push(16'hAAAA); rd_push(16'h5555);
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (rvalid != 0) begin
        total += 3;
        if (rvalid !== (got == 0 ? 3'b100 : 3'b001)) begin bad++; $display("FAIL ret%0d_rvalid got=%b", got, rvalid); end
        if (rdata !== (got == 0 ? 16'hAAAA : 16'h5555)) begin bad++; $display("FAIL ret%0d_rdata got=%h", got, rdata); end
        if (c !== (got == 0 ? 2 : 5)) begin bad++; $display("FAIL ret%0d_latency got=%0d exp=%0d", got, c, got == 0 ? 2 : 5); end
        got++;
      end
    end
    total++;
    if (got !== 2) begin bad++; $display("FAIL ret_count got=%0d exp=2", got); end
    do_reset();
  endtask

  task automatic test_tag_full();
    int  gc = -1;
    bit  seen_v = 0;
    for (int i = 0; i < 16; i++) begin
      req = 3'b100; we = 3'b000; addr[2] = 24'h200 + 24'(i);
      @(negedge clk);
      total++;
      if (gnt !== 3'b100) begin bad++; $display("FAIL fill[%0d]_gnt got=%b exp=100", i, gnt); end
      req = '0;
      @(negedge clk);
    end
    req = 3'b011; we = 3'b001; addr[0] = 24'h300; wdata[0] = 16'h1111; addr[1] = 24'h301;
    @(negedge clk);
    total += 2;
    if (gnt !== 3'b001) begin bad++; $display("FAIL full_wr_gnt got=%b exp=001", gnt); end
    if (cmd !== 41'h1_000300_1111) begin bad++; $display("FAIL full_wr_cmd got=%h exp=10003001111", cmd); end
    req = 3'b010;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (gnt !== 3'b000) begin bad++; $display("FAIL full_rd_blocked got=%b exp=000", gnt); end
    end
    rd_push(16'h1234);
    for (int c = 0; c < 10 && gc < 0; c++) begin
      @(negedge clk);
      if (rvalid != 0) begin
        seen_v = 1;
        total += 3;
        if (rvalid !== 3'b100) begin bad++; $display("FAIL full_ret_rvalid got=%b exp=100", rvalid); end
        if (rdata !== 16'h1234) begin bad++; $display("FAIL full_ret_rdata got=%h exp=1234", rdata); end
        if (c !== 2) begin bad++; $display("FAIL full_ret_latency got=%0d exp=2", c); end
      end
      if (gnt != 0) begin
        gc = c;
        total++;
        if (gnt !== 3'b010) begin bad++; $display("FAIL full_rd_gnt got=%b exp=010", gnt); end
        req = '0;
      end
    end
    total += 2;
    if (seen_v !== 1'b1) begin bad++; $display("FAIL full_ret_seen got=%b exp=1", seen_v); end
    if (gc !== 3) begin bad++; $display("FAIL full_rd_gnt_cycle got=%0d exp=3", gc); end
    do_reset();
  endtask

  task automatic test_backpressure();
    alm = 1'b1; req = 3'b111; we = 3'b111;
    repeat (10) begin
      @(negedge clk);
      total++;
      if (gnt !== 3'b000 || enq !== 1'b0) begin bad++; $display("FAIL bp_hold gnt=%b enq=%b exp 000/0", gnt, enq); end
    end
    alm = 1'b0;
    @(negedge clk);
    total += 2;
    if (gnt !== 3'b001) begin bad++; $display("FAIL bp_resume_gnt got=%b exp=001", gnt); end
    if (enq !== 1'b1) begin bad++; $display("FAIL bp_resume_enq got=%b exp=1", enq); end
    req = '0;
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    req = 3'b001; we = 3'b000; addr[0] = 24'h40;
    @(negedge clk);
    total++;
    if (gnt !== 3'b001) begin bad++; $display("FAIL ar_gnt got=%b exp=001", gnt); end
    req = '0;
    rd_push(16'hCAFE);
    @(negedge clk);
    total++;
    if (deq !== 1'b1) begin bad++; $display("FAIL ar_in_pop deq got=%b exp=1", deq); end
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (deq !== 1'b0) begin bad++; $display("FAIL ar_deq got=%b exp=0", deq); end
    if (cmd !== 41'h0) begin bad++; $display("FAIL ar_cmd got=%h exp=0", cmd); end
    if (gnt !== 3'b000 || enq !== 1'b0) begin bad++; $display("FAIL ar_gnt_enq gnt=%b enq=%b exp 000/0", gnt, enq); end
    if (rvalid !== 3'b000 || rdata !== 16'h0) begin bad++; $display("FAIL ar_ret rvalid=%b rdata=%h exp 000/0", rvalid, rdata); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_push(16'hDEAD);
    repeat (6) begin
      @(negedge clk);
      if (deq || rvalid != 0) seen = 1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL ar_idle_after got deq/rvalid=%b exp=0", seen); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_tag_full();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Shares the single-word command and read-data FIFO ports of the asynchronous SDRAM controller between `N_REQ` requesters (CPU, rasterizer, blitter) in the writer/reader clock domain. Grants requesters round-robin, packs accepted requests into 41-bit command words and enqueues them. Keeps an in-order tag FIFO of read issuers so each returned 16-bit word is routed back to the requester that asked for it. Burst commands are outside this block.

## Interface
- `N_REQ`, 3: number of requesters (2..8).
- `TAG_DEPTH_LOG2`, 4: log2 depth of the outstanding-read tag FIFO.
- `clk` in 1: single clock; writer and reader side of the controller both run on it.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_i` in N_REQ: per-requester request; held with fields stable until `gnt_o`.
- `we_i` in N_REQ: 1 = write, 0 = read.
- `addr_i` in N_REQ×24: word address.
- `wdata_i` in N_REQ×16: write data (ignored for reads).
- `gnt_o` out N_REQ: one-cycle pulse, request accepted.
- `rdata_o` out 16: returned read word, shared bus.
- `rvalid_o` out N_REQ: one-cycle pulse; `rdata_o` belongs to this requester.
- `cmd_d_o` out 41: `{we, addr[23:0], data[15:0]}` to the command FIFO.
- `cmd_enq_o` out 1: command FIFO enqueue.
- `cmd_alm_full_i` in 1: command FIFO almost full.
- `rd_q_i` in 16: read-data FIFO output.
- `rd_deq_o` out 1: read-data FIFO dequeue.
- `rd_empty_i` in 1: read-data FIFO empty.

## Operation
- Eligibility: `req_i[k] && !gnt_o[k] && (we_i[k] || !tag_full)`. No request is accepted while `cmd_alm_full_i` is high.
- Arbitration: round-robin from pointer `rr`. The first eligible index at or after `rr` (mod N_REQ) wins, then `rr` ← winner+1 mod N_REQ. `rr` does not move when there is no winner.
- Accept: the winner is registered in the same cycle as `cmd_d_o` and `cmd_enq_o`=1 and `gnt_o[winner]`=1, all for exactly one cycle. At most one accept per cycle.
- A read accept pushes the winner index into the tag FIFO.
- Return FSM:
  - RET_IDLE: if `!rd_empty_i && !tag_empty`, set `rd_deq_o`=1 and go to RET_POP.
  - RET_POP: set `rd_deq_o`=0 and go to RET_CAP.
  - RET_CAP: `rdata_o` ← `rd_q_i`, `rvalid_o[tag_head]`=1, pop the tag FIFO, go to RET_IDLE.
- The controller serves commands in order, so tags match data strictly FIFO. If data arrives while the tag FIFO is empty, that is a protocol error: the word stays in the FIFO and is not dequeued.
- Simultaneous tag push (accept) and pop (RET_CAP) in the same cycle are both performed; the count is unchanged.
- Tag full (2^TAG_DEPTH_LOG2 outstanding reads): reads are not eligible, writes still are.
- Reset mid-operation clears `rr`, the tag FIFO and the FSM. Outstanding read data already in the controller is orphaned; the system resets both together.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `cmd_enq_o`=0, `rd_deq_o`=0, `cmd_d_o`=0, `rdata_o`=0, `rr`=0, FSM=RET_IDLE, tag FIFO empty.
- Request-to-grant: `req_i` sampled at edge t, `gnt_o`/`cmd_enq_o` high during cycle t+1. Minimum 1 cycle; a requester may re-request in the cycle after `gnt_o`.
- Because of the `!gnt_o[k]` term, a requester is never granted in back-to-back cycles. Different requesters can be granted in consecutive cycles.
- `cmd_alm_full_i` covers the one-cycle registered enqueue latency. `cmd_full` is never reached by this block.
- Read-data FIFO has one-cycle q latency after `rd_deq_o`. Return throughput is 1 word per 3 cycles; `rvalid_o` comes 3 cycles after the RET_IDLE decision.

## Structure
- Package `sdram_arb_pkg`:
  - `sdram_cmd_t` packed struct {we, addr[23:0], data[15:0]}, 41 bits.
  - Constants `SDRAM_ADDR_W`=24, `SDRAM_DATA_W`=16.
  - `ret_state_t` enum.
- Sub-module `tag_fifo`: synchronous FIFO, width $clog2(N_REQ), depth 2^TAG_DEPTH_LOG2, first-word-fall-through. Outputs `head`, `full`, `empty`.

## Test plan
- Single write: req 1, we=1, addr=24'h000123, data=16'hBEEF → `cmd_d_o`=41'h1_000123_BEEF with `cmd_enq_o`, `gnt_o`=3'b010 one cycle after request; no tag pushed.
- Round-robin: all three request writes continuously from reset → grant order 0,1,2,0,1,2…; no requester granted twice in a row.
- Read routing: req 2 reads 0x10, then req 0 reads 0x20; model returns 16'hAAAA, 16'h5555 → `rvalid_o[2]` with AAAA, then `rvalid_o[0]` with 5555, in order.
- Tag full (depth 16): 16 reads outstanding with no returns, req 1 reads and req 0 writes → only the write is granted. After one return, the read is granted.
- Backpressure: `cmd_alm_full_i`=1 for 10 cycles with requests pending → no `cmd_enq_o` or `gnt_o`; resume within 1 cycle of deassert.
- Async reset asserted mid-RET_POP → all outputs 0 immediately; after release, FSM is RET_IDLE and `rd_deq_o` stays 0 with the tag FIFO empty.
